// File: rtl/seg_pkg.sv
`default_nettype none
// ==== seg_pkg: segment patterns, digit codes and FSM states for seg_scan_decoder
// ==== Revision: 1.0
package seg_pkg;

  typedef logic [3:0] digit_t;

  localparam logic [6:0] SEG_0    = 7'b1111110;
  localparam logic [6:0] SEG_1    = 7'b0110000;
  localparam logic [6:0] SEG_2    = 7'b1101101;
  localparam logic [6:0] SEG_3    = 7'b1111001;
  localparam logic [6:0] SEG_4    = 7'b0110011;
  localparam logic [6:0] SEG_5    = 7'b1011011;
  localparam logic [6:0] SEG_6    = 7'b1011111;
  localparam logic [6:0] SEG_7    = 7'b1110000;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1111011;
  localparam logic [6:0] SEG_DASH = 7'b0000001;

  localparam digit_t DIG_DASH = 4'hA;
  localparam digit_t DIG_BAD  = 4'hF;

  localparam logic [1:0] SEL_TENS = 2'b10;
  localparam logic [1:0] SEL_ONES = 2'b01;

  typedef enum logic [1:0] {
    S_TENS = 2'd0,
    S_ONES = 2'd1,
    S_EMIT = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/seg_pattern_decode.sv
`default_nettype none
// ==== seg_pattern_decode: combinational seven-segment pattern to digit code
// ==== Revision: 1.0
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output digit_t     code
);

  always_comb begin
    code = DIG_BAD;
    case (seg)
      SEG_0:    code = 4'd0;
      SEG_1:    code = 4'd1;
      SEG_2:    code = 4'd2;
      SEG_3:    code = 4'd3;
      SEG_4:    code = 4'd4;
      SEG_5:    code = 4'd5;
      SEG_6:    code = 4'd6;
      SEG_7:    code = 4'd7;
      SEG_8:    code = 4'd8;
      SEG_9:    code = 4'd9;
      SEG_DASH: code = DIG_DASH;
      default:  code = DIG_BAD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ==== seg_scan_decoder: debounces a multiplexed 7-seg bus and rebuilds the 2-digit value
// ==== Revision: 1.0
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int NUM_WIDTH     = 7,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           seg,
  input  logic [1:0]           dig_sel,
  output logic [NUM_WIDTH-1:0] number,
  output logic                 num_valid,
  output logic                 dash,
  output logic                 err
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ACC = CW'(STABLE_CYCLES - 2);

  logic [6:0]           seg_q;
  logic [1:0]           sel_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  state_e               state_q, state_d;
  digit_t               tens_q, tens_d, ones_q, ones_d;
  logic [NUM_WIDTH-1:0] number_q, number_d;
  logic                 valid_q, valid_d, dash_q, dash_d, err_q, err_d;
  digit_t               code;
  logic                 blank, same, accept;

  seg_pattern_decode u_dec (
    .seg  (seg_q),
    .code (code)
  );

  assign blank = ~(dig_sel[1] ^ dig_sel[0]);
  assign same  = (seg == seg_q) && (dig_sel == sel_q);
  // Fires once per hold: the counter saturates past this value.
  assign accept = !blank && same && (cnt_q == CNT_ACC);

  always_comb begin
    cnt_d = '0;
    if (!blank && same) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    tens_d   = tens_q;
    ones_d   = ones_q;
    number_d = number_q;
    dash_d   = dash_q;
    err_d    = err_q;
    valid_d  = 1'b0;
    case (state_q)
      S_TENS: begin
        if (accept && sel_q == SEL_TENS) begin
          tens_d  = code;
          state_d = S_ONES;
        end
      end
      S_ONES: begin
        if (accept && sel_q == SEL_TENS) begin
          tens_d = code;
        end else if (accept && sel_q == SEL_ONES) begin
          ones_d  = code;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        dash_d  = (tens_q == DIG_DASH) || (ones_q == DIG_DASH);
        err_d   = (tens_q == DIG_BAD) || (ones_q == DIG_BAD);
        // Any non-numeric digit invalidates the whole value.
        if (tens_q > 4'd9 || ones_q > 4'd9) begin
          number_d = '0;
        end else begin
          number_d = NUM_WIDTH'(tens_q) * NUM_WIDTH'(10) + NUM_WIDTH'(ones_q);
        end
        valid_d = 1'b1;
        state_d = S_TENS;
      end
      default: state_d = S_TENS;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q    <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
      state_q  <= S_TENS;
      tens_q   <= '0;
      ones_q   <= '0;
      number_q <= '0;
      valid_q  <= 1'b0;
      dash_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      seg_q    <= seg;
      sel_q    <= dig_sel;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      tens_q   <= tens_d;
      ones_q   <= ones_d;
      number_q <= number_d;
      valid_q  <= valid_d;
      dash_q   <= dash_d;
      err_q    <= err_d;
    end
  end

  assign number    = number_q;
  assign num_valid = valid_q;
  assign dash      = dash_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// ==== tb_seg_scan_decoder: scoreboard bench with a run-length reference model
// ==== Revision: 1.0
module tb_seg_scan_decoder;

  localparam int NW     = 7;
  localparam int STABLE = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [6:0]    seg;
  logic [1:0]    dig_sel;
  logic [NW-1:0] number;
  logic          num_valid, dash, err;

  seg_scan_decoder #(.NUM_WIDTH(NW), .STABLE_CYCLES(STABLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg       (seg),
    .dig_sel   (dig_sel),
    .number    (number),
    .num_valid (num_valid),
    .dash      (dash),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int num;
    bit dsh;
    bit er;
    int cyc;
  } exp_t;

  exp_t       q[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc   = 0;
  logic [6:0] tab [10];

  initial begin
    tab[0] = 7'b1111110; tab[1] = 7'b0110000; tab[2] = 7'b1101101;
    tab[3] = 7'b1111001; tab[4] = 7'b0110011; tab[5] = 7'b1011011;
    tab[6] = 7'b1011111; tab[7] = 7'b1110000; tab[8] = 7'b1111111;
    tab[9] = 7'b1111011;
  end

  function automatic int model_digit(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (p == tab[i]) return i;
    if (p == 7'b0000001) return 10;
    return 15;
  endfunction

  // Reference: count consecutive identical samples; accept when the run hits STABLE.
  logic [6:0] prev_seg;
  logic [1:0] prev_sel;
  int         run;
  bit         tens_have;
  int         tens_dig;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
      prev_seg  = '0;
      prev_sel  = '0;
      run       = 0;
      tens_have = 0;
    end else begin
      bit blank_s;
      blank_s = (dig_sel == 2'b00) || (dig_sel == 2'b11);
      if (blank_s) run = 0;
      else if (seg == prev_seg && dig_sel == prev_sel) run++;
      else run = 1;
      prev_seg = seg;
      prev_sel = dig_sel;
      if (!blank_s && run == STABLE) begin
        int d;
        d = model_digit(seg);
        if (dig_sel == 2'b10) begin
          tens_dig  = d;
          tens_have = 1;
        end else if (tens_have) begin
          exp_t e;
          e.dsh = (tens_dig == 10) || (d == 10);
          e.er  = (tens_dig == 15) || (d == 15);
          e.num = (tens_dig < 10 && d < 10) ? tens_dig * 10 + d : 0;
          e.cyc = cyc + 1;
          q.push_back(e);
          tens_have = 0;
        end
      end
    end
  end

  int held_num = 0;
  bit held_dsh = 0;
  bit held_er  = 0;

  always @(posedge clk) begin
    #3;
    tests++;
    if (!rst_n) begin
      if (number != 0 || num_valid || dash || err) begin
        fails++;
        $display("FAIL reset_outputs: got num=%0d v=%0b dash=%0b err=%0b, want all 0",
                 number, num_valid, dash, err);
      end
      held_num = 0; held_dsh = 0; held_er = 0;
    end else if (num_valid) begin
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: got num_valid=1 num=%0d at cycle %0d, want no pulse",
                 number, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (number != e.num || dash != e.dsh || err != e.er || cyc != e.cyc) begin
          fails++;
          $display("FAIL frame: got num=%0d dash=%0b err=%0b cyc=%0d, want num=%0d dash=%0b err=%0b cyc=%0d",
                   number, dash, err, cyc, e.num, e.dsh, e.er, e.cyc);
        end
        held_num = e.num; held_dsh = e.dsh; held_er = e.er;
      end
    end else begin
      if (number != held_num || dash != held_dsh || err != held_er) begin
        fails++;
        $display("FAIL hold: got num=%0d dash=%0b err=%0b, want num=%0d dash=%0b err=%0b",
                 number, dash, err, held_num, held_dsh, held_er);
      end
    end
  end

  task automatic drive(input logic [6:0] p, input logic [1:0] s, input int n);
    repeat (n) begin
      @(negedge clk);
      seg     = p;
      dig_sel = s;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    seg     = '0;
    dig_sel = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive('0, 2'b00, 2);

    // Basic frame -> 57
    drive(7'b1011011, 2'b10, 4); drive(7'b1110000, 2'b01, 4); drive('0, 2'b00, 3);
    // Glitch rejection -> 30
    drive(7'b1111001, 2'b10, 3); drive(7'b1111111, 2'b10, 1);
    drive(7'b1111001, 2'b10, 4); drive(7'b1111110, 2'b01, 4); drive('0, 2'b00, 3);
    // Alignment -> 91
    drive(7'b0110000, 2'b01, 4); drive(7'b1111011, 2'b10, 4);
    drive(7'b0110000, 2'b01, 4); drive('0, 2'b00, 3);
    // Dash and undefined pattern
    drive(7'b0000001, 2'b10, 4); drive(7'b1010101, 2'b01, 4); drive('0, 2'b00, 3);
    // Long hold -> 26, single pulse
    drive(7'b1101101, 2'b10, 20); drive(7'b1011111, 2'b01, 20); drive('0, 2'b00, 3);
    // Reset during the ones hold, then a clean frame -> 48
    drive(7'b0110011, 2'b10, 4); drive(7'b1111111, 2'b01, 2);
    pulse_reset();
    drive(7'b1111111, 2'b01, 3); drive('0, 2'b00, 3);
    drive(7'b0110011, 2'b10, 4); drive(7'b1111111, 2'b01, 4); drive('0, 2'b00, 3);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      int r;
      logic [6:0] p;
      logic [1:0] s;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        pulse_reset();
      end else begin
        r = $urandom_range(0, 99);
        if (r < 80) p = tab[$urandom_range(0, 9)];
        else if (r < 88) p = 7'b0000001;
        else p = 7'($urandom_range(0, 127));
        r = $urandom_range(0, 99);
        if (r < 45) s = 2'b10;
        else if (r < 90) s = 2'b01;
        else s = (r < 95) ? 2'b00 : 2'b11;
        drive(p, s, $urandom_range(1, 7));
      end
    end
    drive('0, 2'b00, 6);

    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL missing_pulses: got %0d frames never emitted, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
